// File: rtl/pc_unit_ras.sv
// Program-counter unit with a circular return-address stack.
// Drives the fetch address and predicts return targets for CALL/RET.
// A push onto a full stack overwrites the oldest entry. A pop from an empty
// stack falls back to the supplied target. Both of these events set sticky
// error flags.
module pc_unit_ras #(
   parameter int               WIDTH     = 16,
   parameter logic [WIDTH-1:0] RESET_VEC = '0,
   parameter int               RAS_DEPTH = 4
) (
   input  logic                         clk,
   input  logic                         reset_n,
   input  logic                         enable,
   input  logic [2:0]                   pc_sel,
   input  logic [WIDTH-1:0]             imm,
   input  logic [WIDTH-1:0]             target,
   input  logic                         ras_clr,
   output logic [WIDTH-1:0]             pc,
   output logic [WIDTH-1:0]             ras_top,
   output logic [$clog2(RAS_DEPTH):0]   ras_count,
   output logic                         ras_empty,
   output logic                         ras_full,
   output logic                         ras_overflow,
   output logic                         ras_underflow
);

   localparam int SPW = $clog2(RAS_DEPTH);
   localparam int CW  = SPW + 1;

   localparam logic [2:0] SEL_SEQ  = 3'b000;
   localparam logic [2:0] SEL_BR   = 3'b001;
   localparam logic [2:0] SEL_JMP  = 3'b010;
   localparam logic [2:0] SEL_RET  = 3'b011;
   localparam logic [2:0] SEL_CALL = 3'b100;

   localparam logic [SPW-1:0] SP_ONE    = SPW'(1);
   localparam logic [CW-1:0]  CNT_ONE   = CW'(1);
   localparam logic [CW-1:0]  CNT_DEPTH = CW'(RAS_DEPTH);

   logic [WIDTH-1:0] r_pc;
   logic [WIDTH-1:0] r_entry [RAS_DEPTH];
   logic [SPW-1:0]   r_sp;
   logic [CW-1:0]    r_count;
   logic             r_ovf;
   logic             r_unf;

   logic [WIDTH-1:0] w_pc_inc;
   logic [WIDTH-1:0] w_next_pc;
   logic [WIDTH-1:0] w_top;
   logic [SPW-1:0]   w_sp_dec;
   logic             w_empty;
   logic             w_full;
   logic             w_push;
   logic             w_pop;
   logic             w_set_unf;

   assign w_pc_inc = r_pc + WIDTH'(1);
   assign w_sp_dec = r_sp - SP_ONE;
   assign w_empty  = (r_count == '0);
   assign w_full   = (r_count == CNT_DEPTH);
   // The top entry sits one slot below the write pointer. An empty stack
   // reports zero rather than whatever stale entry is left there.
   assign w_top    = w_empty ? '0 : r_entry[w_sp_dec];

   // Next-PC selection and stack side effects, from the current pc and stack.
   always_comb begin
      w_next_pc = w_pc_inc;
      w_push    = 1'b0;
      w_pop     = 1'b0;
      w_set_unf = 1'b0;
      case (pc_sel)
         SEL_SEQ: w_next_pc = w_pc_inc;
         SEL_BR:  w_next_pc = w_pc_inc + imm;
         SEL_JMP: w_next_pc = target;
         SEL_RET: begin
            if (!w_empty) begin
               w_next_pc = w_top;
               w_pop     = 1'b1;
            end else begin
               w_next_pc = target;
               w_set_unf = 1'b1;
            end
         end
         SEL_CALL: begin
            w_next_pc = target;
            w_push    = 1'b1;
         end
         default: w_next_pc = w_pc_inc;
      endcase
   end

   // Program counter register. It holds its value while the unit is stalled.
   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         r_pc <= RESET_VEC;
      end else if (enable) begin
         r_pc <= w_next_pc;
      end
   end

   // Return-address stack. A flush takes priority over any push, pop or flag
   // set in the same cycle. The pc above has already used the pre-flush top.
   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         for (int i = 0; i < RAS_DEPTH; i++) begin
            r_entry[i] <= '0;
         end
         r_sp    <= '0;
         r_count <= '0;
         r_ovf   <= 1'b0;
         r_unf   <= 1'b0;
      end else if (enable) begin
         if (ras_clr) begin
            r_sp    <= '0;
            r_count <= '0;
            r_ovf   <= 1'b0;
            r_unf   <= 1'b0;
         end else begin
            if (w_push) begin
               r_entry[r_sp] <= w_pc_inc;
               r_sp          <= r_sp + SP_ONE;
               if (w_full) begin
                  r_ovf <= 1'b1;
               end else begin
                  r_count <= r_count + CNT_ONE;
               end
            end
            if (w_pop) begin
               r_sp    <= w_sp_dec;
               r_count <= r_count - CNT_ONE;
            end
            if (w_set_unf) begin
               r_unf <= 1'b1;
            end
         end
      end
   end

   assign pc            = r_pc;
   assign ras_top       = w_top;
   assign ras_count     = r_count;
   assign ras_empty     = w_empty;
   assign ras_full      = w_full;
   assign ras_overflow  = r_ovf;
   assign ras_underflow = r_unf;

endmodule

// File: tb/tb_pc_unit_ras.sv
// Directed bench for pc_unit_ras.
// The unit is built with RESET_VEC=0x0040 and a 4-entry stack.
module tb_pc_unit_ras;

   localparam logic [2:0] SEQ  = 3'b000;
   localparam logic [2:0] BR   = 3'b001;
   localparam logic [2:0] JMP  = 3'b010;
   localparam logic [2:0] RET  = 3'b011;
   localparam logic [2:0] CALL = 3'b100;

   logic        clk;
   logic        reset_n;
   logic        enable;
   logic [2:0]  pc_sel;
   logic [15:0] imm;
   logic [15:0] target;
   logic        ras_clr;
   logic [15:0] pc;
   logic [15:0] ras_top;
   logic [2:0]  ras_count;
   logic        ras_empty;
   logic        ras_full;
   logic        ras_overflow;
   logic        ras_underflow;

   int checks = 0;
   int errors = 0;

   pc_unit_ras #(.WIDTH(16), .RESET_VEC(16'h0040), .RAS_DEPTH(4)) dut (
      .clk          (clk),
      .reset_n      (reset_n),
      .enable       (enable),
      .pc_sel       (pc_sel),
      .imm          (imm),
      .target       (target),
      .ras_clr      (ras_clr),
      .pc           (pc),
      .ras_top      (ras_top),
      .ras_count    (ras_count),
      .ras_empty    (ras_empty),
      .ras_full     (ras_full),
      .ras_overflow (ras_overflow),
      .ras_underflow(ras_underflow)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      assert (obs === exp) else begin
         errors++;
         $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
      end
   endtask

   // Apply one selection and sample the outputs 1 ns after the edge that takes it.
   task automatic step(input logic [2:0] sel, input logic [15:0] tgt, input logic [15:0] im);
      pc_sel = sel;
      target = tgt;
      imm    = im;
      @(posedge clk);
      #1;
   endtask

   task automatic chk_stack(input string tag, input logic [15:0] top, input logic [2:0] cnt,
                            input logic ovf, input logic unf);
      chk({tag, "_top"}, 32'(ras_top), 32'(top));
      chk({tag, "_cnt"}, 32'(ras_count), 32'(cnt));
      chk({tag, "_empty"}, 32'(ras_empty), 32'(cnt == 3'd0));
      chk({tag, "_full"}, 32'(ras_full), 32'(cnt == 3'd4));
      chk({tag, "_ovf"}, 32'(ras_overflow), 32'(ovf));
      chk({tag, "_unf"}, 32'(ras_underflow), 32'(unf));
   endtask

   initial begin
      reset_n = 1'b0;
      enable  = 1'b1;
      pc_sel  = SEQ;
      imm     = '0;
      target  = '0;
      ras_clr = 1'b0;

      // Reset vector, then three sequential fetches.
      #12;
      chk("rst_pc", 32'(pc), 32'h0040);
      chk_stack("rst", 16'h0000, 3'd0, 1'b0, 1'b0);
      reset_n = 1'b1;
      chk("rel_pc", 32'(pc), 32'h0040);
      step(SEQ, 16'h0, 16'h0); chk("seq1", 32'(pc), 32'h0041);
      step(SEQ, 16'h0, 16'h0); chk("seq2", 32'(pc), 32'h0042);
      step(SEQ, 16'h0, 16'h0); chk("seq3", 32'(pc), 32'h0043);
      chk_stack("seq", 16'h0000, 3'd0, 1'b0, 1'b0);

      // Branch backward, jump, wrap-around, and an undefined select acting as SEQ.
      step(JMP, 16'h0010, 16'h0); chk("jmp", 32'(pc), 32'h0010);
      step(BR, 16'h0, 16'hFFFE);  chk("br_neg", 32'(pc), 32'h000F);
      step(BR, 16'h0, 16'h0005);  chk("br_pos", 32'(pc), 32'h0015);
      step(JMP, 16'hFFFF, 16'h0); chk("jmp_ff", 32'(pc), 32'hFFFF);
      step(SEQ, 16'h0, 16'h0);    chk("wrap", 32'(pc), 32'h0000);
      step(3'b110, 16'h0999, 16'h0777); chk("sel6_seq", 32'(pc), 32'h0001);

      // Single call and return.
      step(JMP, 16'h0020, 16'h0);
      step(CALL, 16'h0100, 16'h0);
      chk("call_pc", 32'(pc), 32'h0100);
      chk_stack("call", 16'h0021, 3'd1, 1'b0, 1'b0);
      step(RET, 16'h0555, 16'h0);
      chk("ret_pc", 32'(pc), 32'h0021);
      chk_stack("ret", 16'h0000, 3'd0, 1'b0, 1'b0);

      // Five nested calls overflow the 4-entry stack and drop the oldest entry.
      step(JMP, 16'h0000, 16'h0);
      step(CALL, 16'h0010, 16'h0); chk("c1_cnt", 32'(ras_count), 32'd1);
      step(CALL, 16'h0020, 16'h0);
      step(CALL, 16'h0030, 16'h0);
      step(CALL, 16'h0040, 16'h0);
      chk_stack("c4", 16'h0031, 3'd4, 1'b0, 1'b0);
      step(CALL, 16'h0050, 16'h0);
      chk("c5_pc", 32'(pc), 32'h0050);
      chk_stack("c5", 16'h0041, 3'd4, 1'b1, 1'b0);
      step(RET, 16'h0777, 16'h0); chk("r1", 32'(pc), 32'h0041);
      step(RET, 16'h0777, 16'h0); chk("r2", 32'(pc), 32'h0031);
      step(RET, 16'h0777, 16'h0); chk("r3", 32'(pc), 32'h0021);
      step(RET, 16'h0777, 16'h0); chk("r4", 32'(pc), 32'h0011);
      chk_stack("r4", 16'h0000, 3'd0, 1'b1, 1'b0);
      step(RET, 16'h0777, 16'h0); chk("r5_pc", 32'(pc), 32'h0777);
      chk_stack("r5", 16'h0000, 3'd0, 1'b1, 1'b1);

      // While stalled, the unit ignores CALL and flush requests.
      step(CALL, 16'h0200, 16'h0);
      chk_stack("pre_stall", 16'h0778, 3'd1, 1'b1, 1'b1);
      enable  = 1'b0;
      ras_clr = 1'b1;
      for (int i = 0; i < 3; i++) begin
         step(CALL, 16'h0300, 16'h0);
         chk("stall_pc", 32'(pc), 32'h0200);
         chk_stack("stall", 16'h0778, 3'd1, 1'b1, 1'b1);
      end
      enable = 1'b1;
      step(SEQ, 16'h0, 16'h0);
      chk("clr_pc", 32'(pc), 32'h0201);
      chk_stack("clr", 16'h0000, 3'd0, 1'b0, 1'b0);

      // A flush beats an underflow set in the same cycle. The pc still takes the fallback target.
      step(RET, 16'h0600, 16'h0);
      chk("unf_clr_pc", 32'(pc), 32'h0600);
      chk_stack("unf_clr", 16'h0000, 3'd0, 1'b0, 1'b0);
      ras_clr = 1'b0;

      // RET together with a flush: the pc takes the popped entry and the stack ends up empty.
      step(JMP, 16'h0201, 16'h0);
      step(CALL, 16'h0300, 16'h0);
      step(CALL, 16'h0400, 16'h0);
      chk_stack("two", 16'h0301, 3'd2, 1'b0, 1'b0);
      ras_clr = 1'b1;
      step(RET, 16'h0999, 16'h0);
      ras_clr = 1'b0;
      chk("retclr_pc", 32'(pc), 32'h0301);
      chk_stack("retclr", 16'h0000, 3'd0, 1'b0, 1'b0);

      // An asynchronous reset in the middle of a cycle takes effect at once.
      step(JMP, 16'h1234, 16'h0);
      step(CALL, 16'h0500, 16'h0);
      chk("pre_rst_cnt", 32'(ras_count), 32'd1);
      #2;
      reset_n = 1'b0;
      #1;
      chk("arst_pc", 32'(pc), 32'h0040);
      chk_stack("arst", 16'h0000, 3'd0, 1'b0, 1'b0);
      #3;
      reset_n = 1'b1;
      step(SEQ, 16'h0, 16'h0);
      chk("post_rst_pc", 32'(pc), 32'h0041);

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
